wm8731_i2c_target: RTL and testbench
====================================

WM8731_I2C_TARGET -- requirements
Module: wm8731_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C device address answered.
REQ-002 SHALL have port i_clk, input, 1, the single system clock; it oversamples SCL by at least 8x.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port i_scl, input, 1, the I2C clock from the initiator (asynchronous).
REQ-005 SHALL have port i_sda, input, 1, the I2C data line as seen on the bus (asynchronous).
REQ-006 SHALL have port o_sda, output, 1, the drive value, always 0 (open-drain pull-low).
REQ-007 SHALL have port o_sda_oen, output, 1: 1 pulls SDA low (ACK), 0 releases it.
REQ-008 SHALL have port o_reg_valid, output, 1, a one-cycle strobe that a register write completed.
REQ-009 SHALL have port o_reg_addr, output, 7, the WM8731 register address (byte1[7:1]).
REQ-010 SHALL have port o_reg_data, output, 9, the register data {byte1[0], byte2[7:0]}.
REQ-011 SHALL have port o_busy, output, 1, high from a detected START until STOP or return to idle.
REQ-012 SHALL have port o_abort, output, 1, a one-cycle strobe when a frame is cut short.

Function
REQ-013 SHALL pass i_scl and i_sda through 2-flop synchronizers; all edges and conditions below refer to the synchronized signals.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL sample SDA on the SCL rising edge, MSB first, with a 4-bit bit counter (0..8 per byte).
REQ-016 SHALL implement the states S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE.
REQ-017 S_IDLE -> S_ADDR SHALL occur on START; a START in any state SHALL restart at S_ADDR (repeated start) with the bit counter cleared.
REQ-018 After 8 address bits, if addr==DEV_ADDR and R/W==0, the FSM SHALL go to S_ADDR_ACK; otherwise it SHALL go to S_IGNORE with no ACK.
REQ-019 An ACK SHALL assert o_sda_oen on the first SCL falling edge after the 8th bit and deassert it on the next SCL falling edge.
REQ-020 The FSM SHALL step S_ADDR_ACK -> S_BYTE1 -> S_ACK1 -> S_BYTE2 -> S_ACK2 -> S_IGNORE; each ACK state SHALL end on the SCL falling edge that releases SDA.
REQ-021 o_reg_valid SHALL pulse exactly 1 i_clk after the cycle in which the 8th bit of byte2 is sampled; o_reg_addr/o_reg_data SHALL update that same cycle and hold until the next valid.
REQ-022 In S_IGNORE, further bytes SHALL be NACKed (o_sda_oen stays 0) until START or STOP.
REQ-023 STOP in any state SHALL return the FSM to S_IDLE and release SDA.
REQ-024 START or STOP after the address ACK but before the byte2 8th bit SHALL pulse o_abort for 1 cycle with no o_reg_valid.
REQ-025 Simultaneous SCL and SDA changes on the same synchronized cycle SHALL be treated as a data-bit edge, not START/STOP.

Reset
REQ-026 While i_rst is high at the i_clk edge: state=S_IDLE, bit counter=0, o_sda_oen=0, o_reg_valid=0, o_abort=0, o_busy=0, o_reg_addr=0, o_reg_data=0, synchronizers=1.
REQ-027 Reset mid-frame SHALL release SDA in the same cycle and discard the partial frame without o_abort.

Structure
REQ-028 The state enum, DEV_ADDR default and the address/data widths (7, 9) SHALL live in a shared package i2c_pkg.
REQ-029 Synchronizers plus edge/START/STOP detection SHALL form one sub-module, i2c_bus_sync.

Verification
REQ-030 Bytes 0x34,0x1E,0x00 then STOP -> 3 ACKs; o_reg_valid once with addr 0x0F, data 0x000.
REQ-031 Bytes 0x34,0x09,0x15 -> valid with addr 0x04, data 0x115; o_busy drops after STOP.
REQ-032 Address 0x36 or read 0x35 -> no ACK on any byte, no valid, no abort.
REQ-033 0x34,0x08 then STOP -> o_abort pulse, no valid; repeated START then 0x34,0x0C,0x00 -> valid with addr 0x06, data 0x000.
REQ-034 i_rst high during the ACK of byte1 -> o_sda_oen=0 next cycle, state idle; the next full frame decodes correctly.
REQ-035 A 4th data byte after a valid write -> NACKed, no second valid.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731 I2C register-write target.
package i2c_pkg;

   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
   localparam int         REG_ADDR_W       = 7;
   localparam int         REG_DATA_W       = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_BYTE1,
      S_ACK1,
      S_BYTE2,
      S_ACK2,
      S_IGNORE
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Double-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
   logic [2:0] scl_q, scl_d;
   logic [2:0] sda_q, sda_d;
   logic       scl_high_stable;

   always_comb begin
      scl_d = {scl_q[1:0], i_scl};
      sda_d = {sda_q[1:0], i_sda};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= scl_d;
         sda_q <= sda_d;
      end
   end

   // An SDA change in the same cycle as an SCL change counts as a data edge only.
   assign scl_high_stable = scl_q[1] & scl_q[2];

   assign o_sda      = sda_q[1];
   assign o_scl_rise = scl_q[1] & ~scl_q[2];
   assign o_scl_fall = ~scl_q[1] & scl_q[2];
   assign o_start    = scl_high_stable & sda_q[2] & ~sda_q[1];
   assign o_stop     = scl_high_stable & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/wm8731_i2c_target.sv
// Write-only I2C target decoding 3-byte WM8731 register writes into addr/data strobes.
module wm8731_i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_scl,
   input  logic                  i_sda,
   output logic                  o_sda,
   output logic                  o_sda_oen,
   output logic                  o_reg_valid,
   output logic [REG_ADDR_W-1:0] o_reg_addr,
   output logic [REG_DATA_W-1:0] o_reg_data,
   output logic                  o_busy,
   output logic                  o_abort
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_bus_sync (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_scl      (i_scl),
      .i_sda      (i_sda),
      .o_sda      (sda_s),
      .o_scl_rise (scl_rise),
      .o_scl_fall (scl_fall),
      .o_start    (start_det),
      .o_stop     (stop_det)
   );

   state_t                state_q, state_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic [7:0]            byte1_q, byte1_d;
   logic                  oen_q, oen_d;
   logic                  valid_q, valid_d;
   logic                  abort_q, abort_d;
   logic                  busy_q, busy_d;
   logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [REG_DATA_W-1:0] reg_data_q, reg_data_d;
   logic [7:0]            sample;
   logic                  last_bit;

   assign sample   = {shift_q[6:0], sda_s};
   assign last_bit = scl_rise && (bit_cnt_q == 4'd7);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte1_d    = byte1_q;
      oen_d      = oen_q;
      valid_d    = 1'b0;
      abort_d    = 1'b0;
      busy_d     = busy_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;

      if (start_det || stop_det) begin
         // A frame cut between the address ACK and the last data bit is reported.
         abort_d   = (state_q == S_BYTE1) || (state_q == S_ACK1) || (state_q == S_BYTE2);
         oen_d     = 1'b0;
         bit_cnt_d = 4'd0;
         state_d   = start_det ? S_ADDR : S_IDLE;
         busy_d    = start_det;
      end else begin
         case (state_q)
            S_ADDR, S_BYTE1, S_BYTE2: begin
               if (scl_rise) begin
                  shift_d   = sample;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               if (last_bit) begin
                  case (state_q)
                     S_ADDR:
                        state_d = (sample[7:1] == DEV_ADDR && !sample[0]) ? S_ADDR_ACK : S_IGNORE;
                     S_BYTE1: begin
                        byte1_d = sample;
                        state_d = S_ACK1;
                     end
                     default: begin
                        valid_d    = 1'b1;
                        reg_addr_d = byte1_q[7:1];
                        reg_data_d = {byte1_q[0], sample};
                        state_d    = S_ACK2;
                     end
                  endcase
               end
            end
            S_ADDR_ACK, S_ACK1, S_ACK2: begin
               // First SCL fall drives the ACK, the second releases SDA and moves on.
               if (scl_fall) begin
                  if (!oen_q) begin
                     oen_d = 1'b1;
                  end else begin
                     oen_d     = 1'b0;
                     bit_cnt_d = 4'd0;
                     case (state_q)
                        S_ADDR_ACK: state_d = S_BYTE1;
                        S_ACK1:     state_d = S_BYTE2;
                        default:    state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            default: begin
               oen_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         byte1_q    <= 8'd0;
         oen_q      <= 1'b0;
         valid_q    <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte1_q    <= byte1_d;
         oen_q      <= oen_d;
         valid_q    <= valid_d;
         abort_q    <= abort_d;
         busy_q     <= busy_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
      end
   end

   assign o_sda       = 1'b0;
   assign o_sda_oen   = oen_q;
   assign o_reg_valid = valid_q;
   assign o_reg_addr  = reg_addr_q;
   assign o_reg_data  = reg_data_q;
   assign o_busy      = busy_q;
   assign o_abort     = abort_q;

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// Scoreboard bench: stimulus queues expected ACKs and register events, a monitor checks them.
module tb_wm8731_i2c_target;

   typedef struct packed {
      logic       is_abort;
      logic [6:0] addr;
      logic [8:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       tb_sda;
   logic       sda_bus;
   logic       o_sda, o_sda_oen, o_reg_valid, o_busy, o_abort;
   logic [6:0] o_reg_addr;
   logic [8:0] o_reg_data;
   logic       ack_slot = 1'b0;
   logic       ack_slot_prev = 1'b0;

   int   total = 0;
   int   bad   = 0;
   exp_t ev_q[$];
   logic ack_q[$];

   always #5 clk = ~clk;

   assign sda_bus = o_sda_oen ? o_sda : tb_sda;

   wm8731_i2c_target #(.DEV_ADDR(7'h1A)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_scl       (scl),
      .i_sda       (sda_bus),
      .o_sda       (o_sda),
      .o_sda_oen   (o_sda_oen),
      .o_reg_valid (o_reg_valid),
      .o_reg_addr  (o_reg_addr),
      .o_reg_data  (o_reg_data),
      .o_busy      (o_busy),
      .o_abort     (o_abort)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or an ACK slot opens.
   always @(negedge clk) begin
      exp_t e;
      if (o_reg_valid || o_abort) begin
         if (ev_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: valid=%0b abort=%0b want none", o_reg_valid, o_abort);
         end else begin
            e = ev_q.pop_front();
            check("event_is_abort", 32'(o_abort), 32'(e.is_abort));
            if (!e.is_abort) begin
               check("reg_addr", 32'(o_reg_addr), 32'(e.addr));
               check("reg_data", 32'(o_reg_data), 32'(e.data));
            end
         end
      end
      if (ack_slot && !ack_slot_prev) begin
         if (ack_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack_slot: got slot want none");
         end else begin
            check("ack", 32'(sda_bus == 1'b0), 32'(ack_q.pop_front()));
         end
      end
      ack_slot_prev = ack_slot;
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic push_valid(input logic [6:0] a, input logic [8:0] d);
      exp_t e;
      e.is_abort = 1'b0;
      e.addr     = a;
      e.data     = d;
      ev_q.push_back(e);
   endtask

   task automatic push_abort();
      exp_t e;
      e.is_abort = 1'b1;
      e.addr     = 7'd0;
      e.data     = 9'd0;
      ev_q.push_back(e);
   endtask

   task automatic i2c_bit(input logic b);
      tb_sda = b;
      wclk(4);
      scl = 1'b1;
      wclk(8);
      scl = 1'b0;
      wclk(4);
   endtask

   task automatic i2c_start();
      tb_sda = 1'b1;
      wclk(4);
      scl = 1'b1;
      wclk(4);
      tb_sda = 1'b0;
      wclk(4);
      scl = 1'b0;
      wclk(4);
   endtask

   task automatic i2c_stop();
      tb_sda = 1'b0;
      wclk(4);
      scl = 1'b1;
      wclk(4);
      tb_sda = 1'b1;
      wclk(8);
   endtask

   task automatic i2c_byte(input logic [7:0] b, input logic ack_exp);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      tb_sda = 1'b1;
      wclk(4);
      scl = 1'b1;
      wclk(2);
      ack_q.push_back(ack_exp);
      ack_slot = 1'b1;
      wclk(2);
      ack_slot = 1'b0;
      wclk(4);
      scl = 1'b0;
      wclk(4);
   endtask

   initial begin
      logic [7:0] b1;
      int         n;
      rst = 1'b1;
      scl = 1'b1;
      tb_sda = 1'b1;
      wclk(3);
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_oen", 32'(o_sda_oen), 32'd0);
      check("rst_valid", 32'(o_reg_valid), 32'd0);
      check("rst_abort", 32'(o_abort), 32'd0);
      check("rst_addr", 32'(o_reg_addr), 32'd0);
      check("rst_data", 32'(o_reg_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wclk(5);

      // 0x34,0x1E,0x00 -> addr 0x0F data 0x000
      push_valid(7'h0F, 9'h000);
      i2c_start();
      check("busy_in_frame", 32'(o_busy), 32'd1);
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h1E, 1'b1);
      i2c_byte(8'h00, 1'b1);
      i2c_stop();

      // 0x34,0x09,0x15 -> addr 0x04 data 0x115
      push_valid(7'h04, 9'h115);
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h09, 1'b1);
      i2c_byte(8'h15, 1'b1);
      i2c_stop();
      wclk(10);
      check("busy_after_stop", 32'(o_busy), 32'd0);

      // Foreign address and read request: all NACK, no events
      i2c_start();
      i2c_byte(8'h36, 1'b0);
      i2c_byte(8'h09, 1'b0);
      i2c_byte(8'h15, 1'b0);
      i2c_stop();
      i2c_start();
      i2c_byte(8'h35, 1'b0);
      i2c_byte(8'h09, 1'b0);
      i2c_stop();

      // Cut after byte1 by STOP, then by repeated START, then a good frame
      push_abort();
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h08, 1'b1);
      i2c_stop();
      push_abort();
      push_valid(7'h06, 9'h000);
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h08, 1'b1);
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h0C, 1'b1);
      i2c_byte(8'h00, 1'b1);
      i2c_stop();

      // Extra 4th byte is NACKed, single valid: addr 0x0F data 0x155
      push_valid(7'h0F, 9'h155);
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h1F, 1'b1);
      i2c_byte(8'h55, 1'b1);
      i2c_byte(8'hA5, 1'b0);
      i2c_stop();

      // Reset while byte1 is being ACKed
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      b1 = 8'h0A;
      for (int i = 7; i >= 0; i--) i2c_bit(b1[i]);
      tb_sda = 1'b1;
      n = 0;
      while (!o_sda_oen && n < 40) begin
         @(posedge clk);
         n++;
      end
      check("ack1_oen_before_rst", 32'(o_sda_oen), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_oen", 32'(o_sda_oen), 32'd0);
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wclk(4);
      i2c_stop();

      // Frame after reset: 0x34,0x1E,0x55 -> addr 0x0F data 0x055
      push_valid(7'h0F, 9'h055);
      i2c_start();
      i2c_byte(8'h34, 1'b1);
      i2c_byte(8'h1E, 1'b1);
      i2c_byte(8'h55, 1'b1);
      i2c_stop();

      wclk(50);
      check("events_left", 32'(ev_q.size()), 32'd0);
      check("acks_left", 32'(ack_q.size()), 32'd0);
      check("o_sda_low", 32'(o_sda), 32'd0);
      check("final_busy", 32'(o_busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
